pkt_stat_monitor: RTL
=====================

// Module: pkt_stat_monitor
// PURPOSE
//   Parametrised per-port packet statistics block for the NxN switch benches and debug taps.
//   Edge-detects PORT_NUM packet-marker lines (sop or eop) and keeps one saturating packet counter per port.
//   Keeps one saturating aggregate counter across all ports.
//   A register-style read port returns any counter, with optional clear-on-read; replaces ad-hoc tx/rx totalisers.
// PARAMETERS
//   PORT_NUM    16  number of monitored ports (>=2)
//   CNT_WIDTH   16  per-port counter width
//   EDGE_MODE   0   0 = count rising edges of mark_in, 1 = count falling edges
//   TOT_WIDTH   CNT_WIDTH+$clog2(PORT_NUM)  aggregate counter width (localparam)
//   ADDR_WIDTH  $clog2(PORT_NUM+1)          read address width (localparam)
// PORTS
//   clk         in   1            monitor clock, same domain as mark_in
//   rst_n       in   1            asynchronous, active-low reset
//   mark_in     in   PORT_NUM     per-port packet marker (bit i = port i)
//   beat_in     in   PORT_NUM     per-port data-valid; used only with PKT_STAT_BEAT_CNT_EN
//   clr_all     in   1            synchronous clear of all counters and sat flags
//   rd_en       in   1            read request, single-cycle pulse
//   rd_addr     in   ADDR_WIDTH   0..PORT_NUM-1 = port counter, PORT_NUM = aggregate
//   rd_clr      in   1            with rd_en: clear the addressed counter after read
//   rd_vld      out  1            read data valid, one cycle
//   rd_data     out  TOT_WIDTH    read value, zero-extended for port counters
//   sat_flag    out  PORT_NUM+1   sticky saturation flags, bit PORT_NUM = aggregate
// BEHAVIOUR
//   - Reset: 2-stage shift regs, all counters, rd_vld, rd_data, sat_flag = 0.
//   - Edge detect per port: s0<=mark_in[i], s1<=s0; rise = s0&~s1, fall = ~s0&s1; EDGE_MODE selects.
//     A marker high at reset release counts once in rising mode.
//   - Latency: mark_in transition sampled at edge t; counter shows +1 after edge t+1.
//   - Aggregate increment = popcount of all port edge pulses in the same cycle (0..PORT_NUM).
//     A single-cycle add, no pipeline.
//   - Saturation: a counter that would exceed all-ones holds all-ones and sets its sat_flag bit.
//     The aggregate saturates independently of the port counters. Flags clear only on clr_all or reset.
//   - clr_all: every counter loads that cycle's increment (0/1 per port, popcount for aggregate).
//     No same-cycle event is lost. sat_flag -> 0.
//   - Read: rd_en at edge t -> rd_vld=1 and rd_data=pre-update counter value after edge t, for one cycle.
//     rd_vld=0 the next cycle unless rd_en is held; back-to-back reads are allowed, one per cycle.
//   - rd_clr with rd_en: the addressed counter loads that cycle's increment, same rule as clr_all.
//     Its sat_flag bit also clears.
//   - rd_clr without rd_en is ignored.
//   - rd_addr > PORT_NUM: rd_vld=1, rd_data=0, no clear.
//   - clr_all together with rd_en: read returns pre-clear value; clr_all governs all counters.
//   - Reset asserted mid-operation: immediate clear of everything, no read completes.
// CONFIGURATION
//   PKT_STAT_BEAT_CNT_EN defined:
//     - Adds one saturating CNT_WIDTH beat counter per port, incrementing on each cycle beat_in[i]=1.
//     - Beat input goes through one register stage, so latency is 1 cycle.
//     - Read at rd_addr = PORT_NUM+1+i returns port i's beat counter; ADDR_WIDTH becomes $clog2(2*PORT_NUM+1).
//     - Beat counters follow the same clr_all/rd_clr rules; their saturation is not flagged.
//   PKT_STAT_BEAT_CNT_EN undefined:
//     - beat_in is ignored; no beat counters exist.
//     - Addresses above PORT_NUM read as 0.
// TESTING
//   1. Reset, then one 3-cycle high pulse on mark_in[0], EDGE_MODE=0:
//      read addr 0 -> 1, read addr PORT_NUM -> 1, sat_flag = 0.
//   2. Same-cycle rising edges on all 16 ports, 5 times:
//      each port reads 5, aggregate reads 80.
//   3. CNT_WIDTH=4, 17 pulses on port 3:
//      port 3 reads 15 (saturated), sat_flag[3]=1; aggregate reads 17, sat_flag[16]=0.
//   4. Port 2 at 7, then rd_en+rd_clr on addr 2 in the same cycle as a new edge on port 2:
//      rd_data=7, next read = 1, no loss.
//   5. EDGE_MODE=1, mark_in[5] high from reset for 10 cycles then low:
//      count 1 only after the fall; clr_all afterwards -> every address reads 0.
//   6. PKT_STAT_BEAT_CNT_EN defined, beat_in[1] high 12 cycles:
//      addr PORT_NUM+2 reads 12; addr PORT_NUM+1 reads 0; rd_addr out of range reads 0 with rd_vld=1.

Source files
------------

// File: rtl/pkt_stat_monitor_if.sv
// Bundle of marker/beat inputs, control strobes and the register-style read port of pkt_stat_monitor.
// Widths follow the monitor; the read address widens when PKT_STAT_BEAT_CNT_EN is defined.
interface pkt_stat_monitor_if #(
    parameter int PORT_NUM  = 16,
    parameter int CNT_WIDTH = 16
);
    localparam int TOT_WIDTH  = CNT_WIDTH + $clog2(PORT_NUM);
`ifdef PKT_STAT_BEAT_CNT_EN
    localparam int ADDR_WIDTH = $clog2(2 * PORT_NUM + 1);
`else
    localparam int ADDR_WIDTH = $clog2(PORT_NUM + 1);
`endif

    logic [PORT_NUM-1:0]   mark_in;
    logic [PORT_NUM-1:0]   beat_in;
    logic                  clr_all;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_clr;
    logic                  rd_vld;
    logic [TOT_WIDTH-1:0]  rd_data;
    logic [PORT_NUM:0]     sat_flag;

    modport master (
        output mark_in, beat_in, clr_all, rd_en, rd_addr, rd_clr,
        input  rd_vld, rd_data, sat_flag
    );

    modport slave (
        input  mark_in, beat_in, clr_all, rd_en, rd_addr, rd_clr,
        output rd_vld, rd_data, sat_flag
    );
endinterface

// File: rtl/pkt_stat_monitor.sv
// Per-port saturating packet-marker edge counters plus aggregate; optional PKT_STAT_BEAT_CNT_EN beat counters.
// Counter shows an edge one cycle after it is sampled; reads return data the cycle after rd_en, no backpressure.
module pkt_stat_monitor #(
    parameter int PORT_NUM  = 16,
    parameter int CNT_WIDTH = 16,
    parameter int EDGE_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    pkt_stat_monitor_if.slave bus
);
    localparam int TOT_WIDTH  = CNT_WIDTH + $clog2(PORT_NUM);
`ifdef PKT_STAT_BEAT_CNT_EN
    localparam int ADDR_WIDTH = $clog2(2 * PORT_NUM + 1);
`else
    localparam int ADDR_WIDTH = $clog2(PORT_NUM + 1);
`endif

    logic [PORT_NUM-1:0]  s0, s1, pulse, port_clr;
    logic [CNT_WIDTH-1:0] cnt [PORT_NUM];
    logic [TOT_WIDTH-1:0] tot, tot_inc;
    logic [TOT_WIDTH:0]   tot_sum;
    logic                 tot_clr, rd_clr_en;
    logic [PORT_NUM:0]    sat;
    logic                 rd_vld_q;
    logic [TOT_WIDTH-1:0] rd_data_q, rd_mux;

    assign pulse     = (EDGE_MODE != 0) ? (~s0 & s1) : (s0 & ~s1);
    assign rd_clr_en = bus.rd_en & bus.rd_clr;
    assign tot_clr   = bus.clr_all | (rd_clr_en & (bus.rd_addr == ADDR_WIDTH'(PORT_NUM)));
    assign tot_sum   = {1'b0, tot} + {1'b0, tot_inc};

    always_comb begin
        tot_inc  = '0;
        port_clr = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            tot_inc     = tot_inc + TOT_WIDTH'(pulse[i]);
            port_clr[i] = bus.clr_all | (rd_clr_en & (bus.rd_addr == ADDR_WIDTH'(i)));
        end
    end

    // A cleared counter reloads this cycle's increment so a coincident edge is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0        <= '0;
            s1        <= '0;
            tot       <= '0;
            sat       <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < PORT_NUM; i++) cnt[i] <= '0;
        end else begin
            s0       <= bus.mark_in;
            s1       <= s0;
            rd_vld_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_mux;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (port_clr[i]) begin
                    cnt[i] <= CNT_WIDTH'(pulse[i]);
                    sat[i] <= 1'b0;
                end else if (pulse[i]) begin
                    if (&cnt[i]) sat[i] <= 1'b1;
                    else         cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
            if (tot_clr) begin
                tot           <= tot_inc;
                sat[PORT_NUM] <= 1'b0;
            end else if (tot_sum[TOT_WIDTH]) begin
                tot           <= '1;
                sat[PORT_NUM] <= 1'b1;
            end else begin
                tot <= tot_sum[TOT_WIDTH-1:0];
            end
        end
    end

`ifdef PKT_STAT_BEAT_CNT_EN
    logic [PORT_NUM-1:0]  beat_q, beat_clr;
    logic [CNT_WIDTH-1:0] beat_cnt [PORT_NUM];

    always_comb begin
        beat_clr = '0;
        for (int i = 0; i < PORT_NUM; i++)
            beat_clr[i] = bus.clr_all | (rd_clr_en & (bus.rd_addr == ADDR_WIDTH'(PORT_NUM + 1 + i)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            for (int i = 0; i < PORT_NUM; i++) beat_cnt[i] <= '0;
        end else begin
            beat_q <= bus.beat_in;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (beat_clr[i])
                    beat_cnt[i] <= CNT_WIDTH'(beat_q[i]);
                else if (beat_q[i] && !(&beat_cnt[i]))
                    beat_cnt[i] <= beat_cnt[i] + CNT_WIDTH'(1);
            end
        end
    end
`else
    logic unused_beat;
    assign unused_beat = ^bus.beat_in;
`endif

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < PORT_NUM; i++)
            if (bus.rd_addr == ADDR_WIDTH'(i)) rd_mux = TOT_WIDTH'(cnt[i]);
        if (bus.rd_addr == ADDR_WIDTH'(PORT_NUM)) rd_mux = tot;
`ifdef PKT_STAT_BEAT_CNT_EN
        for (int i = 0; i < PORT_NUM; i++)
            if (bus.rd_addr == ADDR_WIDTH'(PORT_NUM + 1 + i)) rd_mux = TOT_WIDTH'(beat_cnt[i]);
`endif
    end

    assign bus.rd_vld   = rd_vld_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.sat_flag = sat;
endmodule
